// File: rtl/execute_stage_if.sv
// Decode-to-execute bundle: decoded instruction, register values and forwarding sources in,
// registered EX/MEM fields and the combinational source-register ids out.
interface execute_stage_if;
  logic        stall;
  logic        branch_flush;
  logic        jal_flush;
  logic [4:0]  regD_mem;
  logic [4:0]  regD_wb;
  logic [31:0] regD_val_mem;
  logic [31:0] regD_val_wb;
  logic        regwrite_mem;
  logic        regwrite_wb;
  logic        rtype;
  logic        itype;
  logic        load;
  logic        store;
  logic        branch;
  logic        jal;
  logic        jalr;
  logic [31:0] imm;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [4:0]  reg1;
  logic [4:0]  reg2;
  logic [4:0]  regD;
  logic [31:0] reg1val;
  logic [31:0] reg2val;
  logic        regwrite;
  logic        loadF;
  logic        storeF;
  logic        jalF;
  logic        jalrF;
  logic        branch_cond;
  logic [31:0] target;
  logic [31:0] result;
  logic [31:0] store_data;
  logic [4:0]  regDF;
  logic [4:0]  mshr_reg1;
  logic [4:0]  mshr_reg2;

  modport master (
    output stall, branch_flush, jal_flush, regD_mem, regD_wb, regD_val_mem, regD_val_wb,
           regwrite_mem, regwrite_wb, rtype, itype, load, store, branch, jal, jalr,
           imm, inst, pc, reg1, reg2, regD, reg1val, reg2val,
    input  regwrite, loadF, storeF, jalF, jalrF, branch_cond, target, result, store_data,
           regDF, mshr_reg1, mshr_reg2
  );

  modport slave (
    input  stall, branch_flush, jal_flush, regD_mem, regD_wb, regD_val_mem, regD_val_wb,
           regwrite_mem, regwrite_wb, rtype, itype, load, store, branch, jal, jalr,
           imm, inst, pc, reg1, reg2, regD, reg1val, reg2val,
    output regwrite, loadF, storeF, jalF, jalrF, branch_cond, target, result, store_data,
           regDF, mshr_reg1, mshr_reg2
  );
endinterface

// File: rtl/execute_stage.sv
// RV32I execute stage with MEM/WB operand forwarding; EX/MEM outputs registered, 1-cycle latency.
// stall holds the EX/MEM register, either flush loads a bubble (flush beats stall, reset beats both).
module execute_stage (
  input logic          clk,
  input logic          rst,
  execute_stage_if.slave io
);

  typedef struct packed {
    logic        regwrite;
    logic        loadF;
    logic        storeF;
    logic        jalF;
    logic        jalrF;
    logic        branch_cond;
    logic [31:0] target;
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  regDF;
  } exmem_t;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  exmem_t      nxt;
  exmem_t      q;
  logic        use_rs1;
  logic        use_rs2;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic [31:0] a_plus_imm;
  logic [31:0] pc_plus_imm;
  logic [2:0]  funct3;
  logic        alt;
  logic        is_lui;
  logic        is_auipc;
  logic        any_flag;
  logic        valid;
  logic        wr;
  logic        unused_inst;

  function automatic logic [31:0] fwd(
    input logic [4:0]  src,
    input logic [31:0] rf_val,
    input logic        we_mem,
    input logic [4:0]  rd_mem,
    input logic [31:0] val_mem,
    input logic        we_wb,
    input logic [4:0]  rd_wb,
    input logic [31:0] val_wb
  );
    if (src != 5'd0 && we_mem && rd_mem == src)     return val_mem;
    else if (src != 5'd0 && we_wb && rd_wb == src)  return val_wb;
    else                                            return rf_val;
  endfunction

  assign use_rs1 = io.rtype | io.itype | io.load | io.store | io.branch | io.jalr;
  assign use_rs2 = io.rtype | io.store | io.branch;
  assign io.mshr_reg1 = use_rs1 ? io.reg1 : 5'd0;
  assign io.mshr_reg2 = use_rs2 ? io.reg2 : 5'd0;

  assign op_a = fwd(io.reg1, io.reg1val, io.regwrite_mem, io.regD_mem, io.regD_val_mem,
                    io.regwrite_wb, io.regD_wb, io.regD_val_wb);
  assign op_b = fwd(io.reg2, io.reg2val, io.regwrite_mem, io.regD_mem, io.regD_val_mem,
                    io.regwrite_wb, io.regD_wb, io.regD_val_wb);

  assign funct3      = io.inst[14:12];
  assign unused_inst = ^{io.inst[31], io.inst[29:15], io.inst[11:7]};
  assign alu_b       = io.rtype ? op_b : io.imm;
  // inst[30] selects SUB only for register ops; for immediates it only means SRAI
  assign alt         = io.inst[30] & (io.rtype | funct3 == 3'b101);
  assign a_plus_imm  = op_a + io.imm;
  assign pc_plus_imm = io.pc + io.imm;
  assign any_flag    = io.rtype | io.itype | io.load | io.store | io.branch | io.jal | io.jalr;
  assign is_lui      = !any_flag && io.inst[6:0] == OPC_LUI;
  assign is_auipc    = !any_flag && io.inst[6:0] == OPC_AUIPC;

  always_comb begin
    alu_y = '0;
    case (funct3)
      3'b000: alu_y = alt ? op_a - alu_b : op_a + alu_b;
      3'b001: alu_y = op_a << alu_b[4:0];
      3'b010: alu_y = {31'd0, $signed(op_a) < $signed(alu_b)};
      3'b011: alu_y = {31'd0, op_a < alu_b};
      3'b100: alu_y = op_a ^ alu_b;
      3'b101: alu_y = alt ? 32'($signed(op_a) >>> alu_b[4:0]) : op_a >> alu_b[4:0];
      3'b110: alu_y = op_a | alu_b;
      default: alu_y = op_a & alu_b;
    endcase
  end

  always_comb begin
    nxt   = '0;
    wr    = 1'b0;
    valid = 1'b1;
    if (io.rtype || io.itype) begin
      nxt.result = alu_y;
      wr         = 1'b1;
    end else if (io.load || io.store) begin
      nxt.result     = a_plus_imm;
      nxt.store_data = op_b;
      nxt.loadF      = io.load;
      nxt.storeF     = io.store;
      wr             = io.load;
    end else if (io.branch) begin
      nxt.target = pc_plus_imm;
      case (funct3)
        3'b000:  nxt.branch_cond = op_a == op_b;
        3'b001:  nxt.branch_cond = op_a != op_b;
        3'b100:  nxt.branch_cond = $signed(op_a) < $signed(op_b);
        3'b101:  nxt.branch_cond = $signed(op_a) >= $signed(op_b);
        3'b110:  nxt.branch_cond = op_a < op_b;
        3'b111:  nxt.branch_cond = op_a >= op_b;
        default: nxt.branch_cond = 1'b0;
      endcase
    end else if (io.jal || io.jalr) begin
      nxt.target = io.jal ? pc_plus_imm : {a_plus_imm[31:1], 1'b0};
      nxt.result = io.pc + 32'd4;
      nxt.jalF   = io.jal;
      nxt.jalrF  = io.jalr;
      wr         = 1'b1;
    end else if (is_lui || is_auipc) begin
      nxt.result = is_lui ? io.imm : pc_plus_imm;
      wr         = 1'b1;
    end else begin
      valid = 1'b0;
    end
    nxt.regwrite = wr && io.regD != 5'd0;
    nxt.regDF    = valid ? io.regD : 5'd0;
  end

  always_ff @(posedge clk) begin
    if (rst)                                 q <= '0;
    else if (io.branch_flush || io.jal_flush) q <= '0;
    else if (!io.stall)                      q <= nxt;
  end

  assign io.regwrite    = q.regwrite;
  assign io.loadF       = q.loadF;
  assign io.storeF      = q.storeF;
  assign io.jalF        = q.jalF;
  assign io.jalrF       = q.jalrF;
  assign io.branch_cond = q.branch_cond;
  assign io.target      = q.target;
  assign io.result      = q.result;
  assign io.store_data  = q.store_data;
  assign io.regDF       = q.regDF;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: reference model plus per-cycle compare and literal spot checks.
module tb_execute_stage;

  typedef struct packed {
    logic        regwrite;
    logic        loadF;
    logic        storeF;
    logic        jalF;
    logic        jalrF;
    logic        branch_cond;
    logic [31:0] target;
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  regDF;
  } ex_t;

  typedef enum int {C_NONE, C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_JALR} cls_t;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  bit   started = 0;
  ex_t  exp_q;
  ex_t  dut_q;

  execute_stage_if bus ();

  execute_stage dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign dut_q = '{bus.regwrite, bus.loadF, bus.storeF, bus.jalF, bus.jalrF, bus.branch_cond,
                   bus.target, bus.result, bus.store_data, bus.regDF};

  function automatic logic [31:0] operand(input logic [4:0] src, input logic [31:0] rf);
    logic [31:0] v;
    v = rf;
    if (src != 0 && bus.regwrite_wb && bus.regD_wb == src)   v = bus.regD_val_wb;
    if (src != 0 && bus.regwrite_mem && bus.regD_mem == src) v = bus.regD_val_mem;
    return v;
  endfunction

  // What the EX/MEM register must hold after a normal capture of the current inputs
  function automatic ex_t model();
    ex_t         e;
    logic [31:0] a, b, y;
    int          sa, sy;
    int unsigned sh;
    logic [2:0]  f;
    bit          writes, live;
    e = '0;
    a = operand(bus.reg1, bus.reg1val);
    b = operand(bus.reg2, bus.reg2val);
    f = bus.inst[14:12];
    writes = 0;
    live = 1;
    if (bus.rtype || bus.itype) begin
      y = bus.rtype ? b : bus.imm;
      sa = a; sy = y; sh = y % 32;
      if      (f == 0) e.result = (bus.rtype && bus.inst[30]) ? a - y : a + y;
      else if (f == 1) e.result = a * (32'd1 << sh);
      else if (f == 2) e.result = (sa < sy) ? 1 : 0;
      else if (f == 3) e.result = (a < y) ? 1 : 0;
      else if (f == 4) e.result = a ^ y;
      else if (f == 5) e.result = bus.inst[30] ? 32'(sa >>> sh) : a / (32'd1 << sh);
      else if (f == 6) e.result = a | y;
      else             e.result = a & y;
      writes = 1;
    end else if (bus.load || bus.store) begin
      e.result = a + bus.imm;
      e.store_data = b;
      e.loadF = bus.load;
      e.storeF = bus.store;
      writes = bus.load;
    end else if (bus.branch) begin
      sa = a; sy = b;
      e.target = bus.pc + bus.imm;
      case (f)
        0: e.branch_cond = (a == b);
        1: e.branch_cond = (a != b);
        4: e.branch_cond = (sa < sy);
        5: e.branch_cond = !(sa < sy);
        6: e.branch_cond = (a < b);
        7: e.branch_cond = !(a < b);
        default: e.branch_cond = 0;
      endcase
    end else if (bus.jal) begin
      e.target = bus.pc + bus.imm;
      e.result = bus.pc + 4;
      e.jalF = 1;
      writes = 1;
    end else if (bus.jalr) begin
      e.target = (a + bus.imm) & 32'hFFFF_FFFE;
      e.result = bus.pc + 4;
      e.jalrF = 1;
      writes = 1;
    end else if (bus.inst[6:0] == 7'h37) begin
      e.result = bus.imm;
      writes = 1;
    end else if (bus.inst[6:0] == 7'h17) begin
      e.result = bus.pc + bus.imm;
      writes = 1;
    end else begin
      live = 0;
    end
    e.regwrite = writes && bus.regD != 0;
    e.regDF = live ? bus.regD : 5'd0;
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q = '0;
      started = 1;
    end else if (bus.branch_flush || bus.jal_flush) begin
      exp_q = '0;
    end else if (!bus.stall) begin
      exp_q = model();
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [4:0] m1, m2;
      m1 = (bus.rtype || bus.itype || bus.load || bus.store || bus.branch || bus.jalr) ? bus.reg1 : 5'd0;
      m2 = (bus.rtype || bus.store || bus.branch) ? bus.reg2 : 5'd0;
      checks++;
      if (dut_q !== exp_q) begin
        errors++;
        $display("FAIL exmem_reg t=%0t got=%h expected=%h", $time, dut_q, exp_q);
      end
      checks++;
      if (bus.mshr_reg1 !== m1 || bus.mshr_reg2 !== m2) begin
        errors++;
        $display("FAIL mshr t=%0t got=%0d/%0d expected=%0d/%0d", $time,
                 bus.mshr_reg1, bus.mshr_reg2, m1, m2);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_fwd();
    bus.regwrite_mem = 0; bus.regD_mem = 0; bus.regD_val_mem = 0;
    bus.regwrite_wb  = 0; bus.regD_wb  = 0; bus.regD_val_wb  = 0;
  endtask

  task automatic set_inst(input cls_t c, input logic [2:0] f3, input logic alt, input logic [6:0] opc,
                          input logic [31:0] imm, input logic [31:0] pc,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                          input logic [31:0] v1, input logic [31:0] v2);
    bus.rtype = (c == C_R);  bus.itype = (c == C_I);  bus.load = (c == C_LD);
    bus.store = (c == C_ST); bus.branch = (c == C_BR); bus.jal = (c == C_JAL);
    bus.jalr = (c == C_JALR);
    bus.inst = {1'b0, alt, 15'd0, f3, 5'd0, opc};
    bus.imm = imm; bus.pc = pc;
    bus.reg1 = r1; bus.reg2 = r2; bus.regD = rd;
    bus.reg1val = v1; bus.reg2val = v2;
  endtask

  initial begin
    rst = 1;
    bus.stall = 0; bus.branch_flush = 0; bus.jal_flush = 0;
    clear_fwd();
    set_inst(C_NONE, 0, 0, 7'h00, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("reset_result", bus.result, 0);
    chk("reset_regwrite", {31'd0, bus.regwrite}, 0);
    rst = 0;

    // ADD x3 = x1 + x2
    set_inst(C_R, 3'b000, 0, 7'h33, 0, 32'h10, 1, 2, 3, 5, 7);
    step();
    chk("add_result", bus.result, 12);
    chk("add_regDF", {27'd0, bus.regDF}, 3);
    chk("add_regwrite", {31'd0, bus.regwrite}, 1);

    bus.regwrite_mem = 1; bus.regD_mem = 1; bus.regD_val_mem = 100;
    bus.regwrite_wb = 1;  bus.regD_wb = 1;  bus.regD_val_wb = 50;
    step();
    chk("fwd_mem_wins", bus.result, 107);
    bus.regD_mem = 0; bus.regD_wb = 0;
    step();
    chk("fwd_x0_ignored", bus.result, 12);
    clear_fwd();

    // SUB with WB forward on rs2 only
    bus.regwrite_wb = 1; bus.regD_wb = 2; bus.regD_val_wb = 20;
    set_inst(C_R, 3'b000, 1, 7'h33, 0, 0, 1, 2, 4, 5, 7);
    step();
    chk("sub_fwd_wb", bus.result, 32'hFFFF_FFF1);
    clear_fwd();

    set_inst(C_R, 3'b101, 1, 7'h33, 0, 0, 1, 2, 4, 32'h8000_0000, 4);
    step();
    chk("sra", bus.result, 32'hF800_0000);
    set_inst(C_R, 3'b101, 0, 7'h33, 0, 0, 1, 2, 4, 32'h8000_0000, 4);
    step();
    chk("srl", bus.result, 32'h0800_0000);
    set_inst(C_I, 3'b101, 1, 7'h13, 4, 0, 1, 0, 4, 32'h8000_0000, 0);
    step();
    chk("srai", bus.result, 32'hF800_0000);
    set_inst(C_I, 3'b000, 1, 7'h13, 3, 0, 1, 0, 4, 5, 0);
    step();
    chk("addi_alt_ignored", bus.result, 8);
    set_inst(C_I, 3'b011, 0, 7'h13, 32'hFFFF_FFFF, 0, 1, 0, 4, 5, 0);
    step();
    chk("sltiu", bus.result, 1);
    set_inst(C_R, 3'b010, 0, 7'h33, 0, 0, 1, 2, 4, 32'hFFFF_FFFF, 1);
    step();
    chk("slt", bus.result, 1);
    set_inst(C_R, 3'b001, 0, 7'h33, 0, 0, 1, 2, 4, 3, 32'h21);
    step();
    chk("sll_shamt5", bus.result, 6);

    set_inst(C_R, 3'b000, 0, 7'h33, 0, 0, 1, 2, 0, 5, 7);
    step();
    chk("rd0_no_write", {31'd0, bus.regwrite}, 0);

    set_inst(C_NONE, 0, 0, 7'h37, 32'h1234_5000, 0, 0, 0, 5, 0, 0);
    step();
    chk("lui", bus.result, 32'h1234_5000);
    set_inst(C_NONE, 0, 0, 7'h17, 32'h1000, 32'h100, 0, 0, 5, 0, 0);
    step();
    chk("auipc", bus.result, 32'h1100);
    set_inst(C_NONE, 0, 0, 7'h00, 32'h55, 32'h100, 0, 0, 5, 0, 0);
    step();
    chk("bubble_regDF", {27'd0, bus.regDF}, 0);

    set_inst(C_BR, 3'b100, 0, 7'h63, 32'h10, 32'h40, 1, 2, 0, 32'hFFFF_FFFF, 1);
    step();
    chk("blt_cond", {31'd0, bus.branch_cond}, 1);
    chk("blt_target", bus.target, 32'h50);
    chk("blt_regwrite", {31'd0, bus.regwrite}, 0);
    set_inst(C_BR, 3'b110, 0, 7'h63, 32'h10, 32'h40, 1, 2, 0, 32'hFFFF_FFFF, 1);
    step();
    chk("bltu_cond", {31'd0, bus.branch_cond}, 0);

    set_inst(C_JALR, 3'b000, 0, 7'h67, 4, 32'h20, 1, 0, 1, 32'h101, 0);
    step();
    chk("jalr_target", bus.target, 32'h104);
    chk("jalr_result", bus.result, 32'h24);
    chk("jalr_flag", {31'd0, bus.jalrF}, 1);
    set_inst(C_JAL, 3'b000, 0, 7'h6F, 32'h800, 32'h20, 0, 0, 1, 0, 0);
    step();
    chk("jal_target", bus.target, 32'h820);

    // SW then stall: register must freeze while inputs change
    set_inst(C_ST, 3'b010, 0, 7'h23, 8, 0, 1, 2, 0, 32'h1000, 32'hDEAD);
    step();
    chk("sw_addr", bus.result, 32'h1008);
    chk("sw_data", bus.store_data, 32'hDEAD);
    bus.stall = 1;
    set_inst(C_R, 3'b000, 0, 7'h33, 0, 0, 1, 2, 3, 5, 7);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold_storeF", {31'd0, bus.storeF}, 1);
      chk("stall_hold_result", bus.result, 32'h1008);
    end
    bus.branch_flush = 1;
    step();
    chk("flush_over_stall_storeF", {31'd0, bus.storeF}, 0);
    chk("flush_over_stall_regwrite", {31'd0, bus.regwrite}, 0);
    bus.branch_flush = 0;
    bus.stall = 0;

    step();
    chk("after_flush_add", bus.result, 12);
    bus.jal_flush = 1;
    step();
    chk("jal_flush_result", bus.result, 0);
    bus.jal_flush = 0;
    step();
    rst = 1;
    bus.stall = 1;
    step();
    chk("mid_reset_result", bus.result, 0);
    chk("mid_reset_regDF", {27'd0, bus.regDF}, 0);
    rst = 0;
    bus.stall = 0;
    step();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 The module SHALL have these ports (name  direction  width  meaning):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- stall, branch_flush, jal_flush  in  1 each  hazard controls
- regD_mem, regD_wb  in  5 each  destination registers of MEM and WB
- regD_val_mem, regD_val_wb  in  32 each  results of MEM and WB
- regwrite_mem, regwrite_wb  in  1 each  MEM/WB write enables
- rtype, itype, load, store, branch, jal, jalr  in  1 each  decoded class flags, at most one set
- imm, inst, pc  in  32 each  decoded immediate, raw instruction, instruction PC
- reg1, reg2, regD  in  5 each  rs1, rs2, rd
- reg1val, reg2val  in  32 each  register-file values
- regwrite, loadF, storeF, jalF, jalrF, branch_cond  out  1 each  registered EX/MEM flags
- target, result, store_data  out  32 each  registered EX/MEM data
- regDF  out  5  registered rd
- mshr_reg1, mshr_reg2  out  5 each  combinational source registers of the instruction in EX

Function
REQ-003 rs1 usage: rtype, itype, load, store, branch, jalr. rs2 usage: rtype, store, branch.
REQ-004 Operand forwarding is combinational. A forward matches only when the register is nonzero, the write enable is set, and regD equals the source register.
REQ-005 Forwarding priority: MEM (regD_val_mem) over WB (regD_val_wb) over the register-file value.
REQ-006 mshr_reg1 SHALL equal reg1 when rs1 is used, else 0. mshr_reg2 SHALL equal reg2 when rs2 is used, else 0.
REQ-007 rtype: funct3 = inst[14:12], alternate bit = inst[30]. Operations: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND. Shift amount = operand B[4:0]. All arithmetic is 32-bit wrap-around.
REQ-008 itype: same operations with B = imm. SUB does not exist; inst[30] selects SRAI only when funct3 = 101.
REQ-009 load and store: result = rs1 + imm; store_data = forwarded rs2.
REQ-010 branch: branch_cond per funct3 (BEQ, BNE, BLT, BGE, BLTU, BGEU); target = pc + imm; regwrite = 0.
REQ-011 jal: target = pc + imm. jalr: target = (rs1 + imm) with bit 0 cleared. Both: result = pc + 4, regwrite = 1.
REQ-012 No flag set, inst[6:0] = 0110111 (LUI): result = imm, regwrite = 1.
REQ-013 No flag set, inst[6:0] = 0010111 (AUIPC): result = pc + imm, regwrite = 1.
REQ-014 Any other no-flag instruction SHALL be a bubble.
REQ-015 regwrite = 1 for rtype, itype, load, jal, jalr, LUI, AUIPC, and only when regD != 0.
REQ-016 All outputs except mshr_reg1/mshr_reg2 update on the rising edge. Latency is one cycle.
REQ-017 Priority each edge: rst, then (branch_flush or jal_flush), then stall, then normal capture.
REQ-018 Flush loads a bubble: all flags 0, regDF 0, target/result/store_data 0.
REQ-019 stall holds every registered output unchanged.
REQ-020 Simultaneous flush and stall: the flush wins.

Reset
REQ-021 rst at a rising edge SHALL clear every registered output to 0, including during stall or flush.
REQ-022 mshr_reg1/mshr_reg2 remain combinational during reset.

Verification
REQ-023 ADD x3=x1+x2, reg1val=5, reg2val=7, no forwards -> next edge: result=12, regDF=3, regwrite=1.
REQ-024 Same ADD with regwrite_mem=1, regD_mem=1, val_mem=100, and regwrite_wb=1, regD_wb=1, val_wb=50 -> result=107 (MEM wins). Repeat with regD=0 on both forwards -> result=12.
REQ-025 BLT, rs1=-1, rs2=1, pc=0x40, imm=0x10 -> branch_cond=1, target=0x50, regwrite=0. BLTU, same operands -> branch_cond=0.
REQ-026 JALR, rs1=0x101, imm=4, pc=0x20 -> target=0x104, result=0x24, jalrF=1.
REQ-027 Valid SW in EX with stall=1 for 3 cycles -> outputs unchanged. Then branch_flush=1 with stall=1 -> bubble (storeF=0, regwrite=0).
REQ-028 rst=1 mid-stream -> all registered outputs 0 after the edge.
